t_ff_async: RTL and testbench



---
 rtl/t_ff_async.sv | 34 +++
 tb/tb_t_ff_async.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/t_ff_async.sv
// Bank of WIDTH independent toggle flip-flops with a shared clock and a
// synchronous active-high reset; qn is the combinational complement of q.
module t_ff_async #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] toggle_d;
  logic [WIDTH-1:0] toggle_q;

  // Reset wins over t, so a toggle requested in the reset cycle is dropped.
  always_comb begin
    toggle_d = toggle_q ^ t;
    if (rst) begin
      toggle_d = RST_VAL;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    toggle_q <= toggle_d;
  end

  assign q  = toggle_q;
  assign qn = ~toggle_q;

endmodule

// File: tb/tb_t_ff_async.sv
// Directed bench for t_ff_async: a 1-bit instance for the timing scenarios and
// a 4-bit instance with a non-zero reset value for per-bit independence.
module tb_t_ff_async;

  logic       clk;
  logic       rst;
  logic       t;
  logic       q;
  logic       qn;

  logic       rst4;
  logic [3:0] t4;
  logic [3:0] q4;
  logic [3:0] qn4;

  int cmp_count;
  int err_count;

  t_ff_async u_dut (
    .clk (clk),
    .rst (rst),
    .t   (t),
    .q   (q),
    .qn  (qn)
  );

  t_ff_async #(
    .WIDTH   (4),
    .RST_VAL (4'b1010)
  ) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .t   (t4),
    .q   (q4),
    .qn  (qn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then land 1 ns after the next rising edge.
  task automatic cycle(input logic r, input logic tt);
    @(negedge clk);
    rst = r;
    t   = tt;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle4(input logic r, input logic [3:0] tt);
    @(negedge clk);
    rst4 = r;
    t4   = tt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
    cmp_count++;
    if (q !== 1'b0) begin
      err_count++;
      $display("FAIL reset_q: got %b expected 0", q);
    end
    cmp_count++;
    if (qn !== 1'b1) begin
      err_count++;
      $display("FAIL reset_qn: got %b expected 1", qn);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0);
      cmp_count++;
      if (q !== 1'b0) begin
        err_count++;
        $display("FAIL reset_hold[%0d]: got %b expected 0", i, q);
      end
    end
  endtask

  task automatic test_toggle;
    logic exp_q;
    exp_q = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1);
      exp_q = (i % 2 == 0) ? 1'b1 : 1'b0;
      cmp_count++;
      if (q !== exp_q || qn !== ~exp_q) begin
        err_count++;
        $display("FAIL toggle[%0d]: got q=%b qn=%b expected q=%b qn=%b", i, q, qn, exp_q, ~exp_q);
      end
      // Midway through the cycle the value must not have moved yet.
      #3;
      cmp_count++;
      if (q !== exp_q) begin
        err_count++;
        $display("FAIL toggle_mid[%0d]: got %b expected %b", i, q, exp_q);
      end
    end
  endtask

  task automatic test_hold;
    cycle(1'b0, 1'b1);
    cmp_count++;
    if (q !== 1'b1) begin
      err_count++;
      $display("FAIL hold_setup: got %b expected 1", q);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0);
      cmp_count++;
      if (q !== 1'b1) begin
        err_count++;
        $display("FAIL hold[%0d]: got %b expected 1", i, q);
      end
    end
    cycle(1'b0, 1'b1);
    cmp_count++;
    if (q !== 1'b0) begin
      err_count++;
      $display("FAIL hold_release: got %b expected 0", q);
    end
  endtask

  task automatic test_mid_cycle_reset;
    cycle(1'b0, 1'b1);
    cmp_count++;
    if (q !== 1'b1) begin
      err_count++;
      $display("FAIL midrst_setup: got %b expected 1", q);
    end
    // Now 1 ns past the edge: pulse rst from +2 ns to +5 ns.
    t = 1'b0;
    #1 rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    cmp_count++;
    if (q !== 1'b1) begin
      err_count++;
      $display("FAIL midrst_pulse: got %b expected 1", q);
    end
    @(posedge clk);
    #1;
    cmp_count++;
    if (q !== 1'b1) begin
      err_count++;
      $display("FAIL midrst_after_edge: got %b expected 1", q);
    end
    @(negedge clk);
    rst = 1'b1;
    #4;
    cmp_count++;
    if (q !== 1'b1) begin
      err_count++;
      $display("FAIL midrst_before_edge: got %b expected 1", q);
    end
    @(posedge clk);
    #1;
    cmp_count++;
    if (q !== 1'b0) begin
      err_count++;
      $display("FAIL midrst_at_edge: got %b expected 0", q);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_priority;
    cycle(1'b0, 1'b1);
    cmp_count++;
    if (q !== 1'b1) begin
      err_count++;
      $display("FAIL prio_setup: got %b expected 1", q);
    end
    cycle(1'b1, 1'b1);
    cmp_count++;
    if (q !== 1'b0) begin
      err_count++;
      $display("FAIL prio_reset_wins: got %b expected 0", q);
    end
    cycle(1'b0, 1'b1);
    cmp_count++;
    if (q !== 1'b1) begin
      err_count++;
      $display("FAIL prio_first_toggle: got %b expected 1", q);
    end
  endtask

  task automatic test_multi_bit;
    cycle4(1'b1, 4'b1111);
    cmp_count++;
    if (q4 !== 4'b1010 || qn4 !== 4'b0101) begin
      err_count++;
      $display("FAIL multi_reset: got q=%b qn=%b expected q=1010 qn=0101", q4, qn4);
    end
    cycle4(1'b0, 4'b0011);
    cmp_count++;
    if (q4 !== 4'b1001 || qn4 !== 4'b0110) begin
      err_count++;
      $display("FAIL multi_t0011: got q=%b qn=%b expected q=1001 qn=0110", q4, qn4);
    end
    cycle4(1'b0, 4'b1100);
    cmp_count++;
    if (q4 !== 4'b0101 || qn4 !== 4'b1010) begin
      err_count++;
      $display("FAIL multi_t1100: got q=%b qn=%b expected q=0101 qn=1010", q4, qn4);
    end
    cycle4(1'b0, 4'b0000);
    cmp_count++;
    if (q4 !== 4'b0101) begin
      err_count++;
      $display("FAIL multi_hold: got %b expected 0101", q4);
    end
  endtask

  initial begin
    cmp_count = 0;
    err_count = 0;
    rst  = 1'b1;
    t    = 1'b0;
    rst4 = 1'b1;
    t4   = 4'b0000;
    test_reset;
    test_toggle;
    test_hold;
    test_mid_cycle_reset;
    test_reset_priority;
    test_multi_bit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
